// File: rtl/pp_carry_shift_unit_if.sv
// Bundle for the Booth multiplier's partial-product/carry shift register:
// start handshake, CSA-row step input, register views and done handshake.
// Optional macro: PP_FINAL_SUM_EN adds product_out.
interface pp_carry_shift_unit_if #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 4
);
   localparam int STEPS = WIDTH / SHIFT;
   localparam int CW    = $clog2(STEPS + 1);

   logic                     start_valid;
   logic                     start_ready;
   logic [WIDTH-1:0]         multiplier_in;
   logic                     step_en;
   logic [WIDTH+SHIFT-2:0]   pp_din;
   logic [WIDTH+SHIFT-2:0]   carry_din;
   logic [SHIFT:0]           booth_window;
   logic [2*WIDTH-1:0]       pp_dout;
   logic [2*WIDTH-1:0]       carry_dout;
   logic [CW-1:0]            step_cnt;
   logic                     busy;
   logic                     done_valid;
   logic                     done_ready;
`ifdef PP_FINAL_SUM_EN
   logic [2*WIDTH-1:0]       product_out;
`endif

   modport master (
`ifdef PP_FINAL_SUM_EN
      input  product_out,
`endif
      output start_valid, multiplier_in, step_en, pp_din, carry_din, done_ready,
      input  start_ready, booth_window, pp_dout, carry_dout, step_cnt, busy, done_valid
   );

   modport slave (
`ifdef PP_FINAL_SUM_EN
      output product_out,
`endif
      input  start_valid, multiplier_in, step_en, pp_din, carry_din, done_ready,
      output start_ready, booth_window, pp_dout, carry_dout, step_cnt, busy, done_valid
   );
endinterface

// File: rtl/pp_carry_shift_unit.sv
// Partial-product/carry accumulation register for a radix-2^SHIFT sequential
// Booth multiplier. Loads the multiplier, retires SHIFT bits per step_en,
// then presents the pp/carry pair on a done handshake.
// Optional macro: PP_FINAL_SUM_EN inserts a SUM state that registers
// pp + carry onto product_out before DONE.
module pp_carry_shift_unit #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pp_carry_shift_unit_if.slave bus
);
   localparam int STEPS = WIDTH / SHIFT;
   localparam int CW    = $clog2(STEPS + 1);
   localparam int DW    = WIDTH + SHIFT - 1;

   if ((SHIFT < 1) || (SHIFT > 8) || ((WIDTH % SHIFT) != 0) || (WIDTH < 2 * SHIFT)) begin : g_param_err
      $error("pp_carry_shift_unit: illegal WIDTH/SHIFT combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_SUM} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   pp_q, pp_d;
   logic [2*WIDTH-1:0]   carry_q, carry_d;
   logic                 last_q, last_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 last_step;
`ifdef PP_FINAL_SUM_EN
   logic [2*WIDTH-1:0]   prod_q, prod_d;
`endif

   assign last_step = bus.step_en && (cnt_q == CW'(STEPS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.start_valid) state_d = S_RUN;
         S_RUN: begin
            if (last_step) begin
`ifdef PP_FINAL_SUM_EN
               state_d = S_SUM;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_SUM:  state_d = S_DONE;
         S_DONE: if (bus.done_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake/status outputs decoded from state
   always_comb begin
      bus.start_ready = (state_q == S_IDLE);
      bus.busy        = (state_q == S_RUN) || (state_q == S_SUM);
      bus.done_valid  = (state_q == S_DONE);
   end

   // Datapath next-state: load, shift-in of CSA row, final sum
   always_comb begin
      pp_d    = pp_q;
      carry_d = carry_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
`ifdef PP_FINAL_SUM_EN
      prod_d  = prod_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               pp_d    = {{WIDTH{1'b0}}, bus.multiplier_in};
               carry_d = '0;
               last_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (bus.step_en) begin
               // Sign-extend the CSA sum by one bit; carry gets a zero slot
               // where the next row's weight starts.
               pp_d    = {bus.pp_din[DW-1], bus.pp_din, pp_q[WIDTH-1:SHIFT]};
               carry_d = {bus.carry_din, 1'b0, carry_q[WIDTH-1:SHIFT]};
               last_d  = pp_q[SHIFT-1];
               cnt_d   = cnt_q + CW'(1);
            end
         end
`ifdef PP_FINAL_SUM_EN
         S_SUM: prod_d = pp_q + carry_q;
`endif
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pp_q    <= '0;
         carry_q <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef PP_FINAL_SUM_EN
         prod_q  <= '0;
`endif
      end else begin
         pp_q    <= pp_d;
         carry_q <= carry_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
`ifdef PP_FINAL_SUM_EN
         prod_q  <= prod_d;
`endif
      end
   end

   assign bus.booth_window = {pp_q[SHIFT-1:0], last_q};
   assign bus.pp_dout      = pp_q;
   assign bus.carry_dout   = carry_q;
   assign bus.step_cnt     = cnt_q;
`ifdef PP_FINAL_SUM_EN
   assign bus.product_out  = prod_q;
`endif
endmodule

// File: tb/tb_pp_carry_shift_unit.sv
// Directed bench for pp_carry_shift_unit at WIDTH=8, SHIFT=4 (two steps).
// Optional macro: PP_FINAL_SUM_EN enables the SUM-state expectations.
module tb_pp_carry_shift_unit;
   localparam int WIDTH = 8;
   localparam int SHIFT = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pp_carry_shift_unit_if #(.WIDTH(WIDTH), .SHIFT(SHIFT)) bus ();

   pp_carry_shift_unit #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [15:0] pp, input logic [15:0] cy,
                             input logic [1:0] cnt);
      check({tag, ".pp"},    64'(bus.pp_dout),    64'(pp));
      check({tag, ".carry"}, 64'(bus.carry_dout), 64'(cy));
      check({tag, ".cnt"},   64'(bus.step_cnt),   64'(cnt));
   endtask

   task automatic check_status(input string tag, input logic sr, input logic bz, input logic dv);
      check({tag, ".start_ready"}, 64'(bus.start_ready), 64'(sr));
      check({tag, ".busy"},        64'(bus.busy),        64'(bz));
      check({tag, ".done_valid"},  64'(bus.done_valid),  64'(dv));
   endtask

   initial begin
      rst               = 1'b1;
      bus.start_valid   = 1'b1;   // reset must win over a start request
      bus.multiplier_in = 8'hFF;
      bus.step_en       = 1'b0;
      bus.pp_din        = '0;
      bus.carry_din     = '0;
      bus.done_ready    = 1'b0;
      tick();
      tick();
      check_regs("reset", 16'h0000, 16'h0000, 2'd0);
      check_status("reset", 1'b1, 1'b0, 1'b0);
      check("reset.bw", 64'(bus.booth_window), 64'(5'b00000));
      rst             = 1'b0;
      bus.start_valid = 1'b0;

      // Load 0xA5
      bus.start_valid   = 1'b1;
      bus.multiplier_in = 8'hA5;
      tick();
      bus.start_valid = 1'b0;
      check_regs("load", 16'h00A5, 16'h0000, 2'd0);
      check_status("load", 1'b0, 1'b1, 1'b0);
      check("load.bw", 64'(bus.booth_window), 64'(5'b01010));

      // Step 1
      bus.step_en   = 1'b1;
      bus.pp_din    = 11'h7FF;
      bus.carry_din = 11'h001;
      tick();
      bus.step_en = 1'b0;
      check_regs("step1", 16'hFFFA, 16'h0020, 2'd1);
      check("step1.bw", 64'(bus.booth_window), 64'(5'b10100));
      check("step1.dv", 64'(bus.done_valid), 64'(1'b0));

      // Two idle cycles with garbage on the data inputs
      bus.pp_din    = 11'h555;
      bus.carry_din = 11'h2AA;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_regs("gap", 16'hFFFA, 16'h0020, 2'd1);
         check("gap.dv", 64'(bus.done_valid), 64'(1'b0));
      end

      // Step 2 (final)
      bus.step_en   = 1'b1;
      bus.pp_din    = 11'h123;
      bus.carry_din = 11'h456;
      tick();
      bus.step_en = 1'b0;
      check_regs("step2", 16'h123F, 16'h8AC2, 2'd2);
      check("step2.bw", 64'(bus.booth_window), 64'(5'b11111));
`ifdef PP_FINAL_SUM_EN
      check_status("sum", 1'b0, 1'b1, 1'b0);
      tick();
      check("sum.product", 64'(bus.product_out), 64'(16'h9D01));
`endif
      check_status("done", 1'b0, 1'b0, 1'b1);

      // DONE hold with stray start/step pulses
      for (int i = 0; i < 5; i++) begin
         bus.start_valid   = (i == 1);
         bus.step_en       = (i == 3);
         bus.multiplier_in = 8'h11;
         tick();
         check_regs("hold", 16'h123F, 16'h8AC2, 2'd2);
         check("hold.dv", 64'(bus.done_valid), 64'(1'b1));
`ifdef PP_FINAL_SUM_EN
         check("hold.product", 64'(bus.product_out), 64'(16'h9D01));
`endif
      end
      bus.step_en = 1'b0;

      // Done handshake with start_valid held: no back-to-back load
      bus.done_ready  = 1'b1;
      bus.start_valid = 1'b1;
      tick();
      bus.done_ready  = 1'b0;
      bus.start_valid = 1'b0;
      check_status("idle", 1'b1, 1'b0, 1'b0);
      check_regs("idle", 16'h123F, 16'h8AC2, 2'd2);

      // Reset mid-RUN after one of two steps
      bus.start_valid   = 1'b1;
      bus.multiplier_in = 8'h3C;
      tick();
      bus.start_valid = 1'b0;
      bus.step_en     = 1'b1;
      bus.pp_din      = 11'h0AA;
      bus.carry_din   = 11'h011;
      tick();
      bus.step_en = 1'b0;
      rst         = 1'b1;
      tick();
      rst = 1'b0;
      check_regs("abort", 16'h0000, 16'h0000, 2'd0);
      check_status("abort", 1'b1, 1'b0, 1'b0);
      check("abort.bw", 64'(bus.booth_window), 64'(5'b00000));

      // Fresh operation 0x3C runs to completion
      bus.start_valid   = 1'b1;
      bus.multiplier_in = 8'h3C;
      tick();
      bus.start_valid = 1'b0;
      check_regs("load2", 16'h003C, 16'h0000, 2'd0);
      check("load2.bw", 64'(bus.booth_window), 64'(5'b11000));
      bus.step_en   = 1'b1;
      bus.pp_din    = 11'h000;
      bus.carry_din = 11'h000;
      tick();
      check_regs("r2s1", 16'h0003, 16'h0000, 2'd1);
      check("r2s1.bw", 64'(bus.booth_window), 64'(5'b00111));
      bus.pp_din    = 11'h7FF;
      bus.carry_din = 11'h7FF;
      tick();
      bus.step_en = 1'b0;
      check_regs("r2s2", 16'hFFF0, 16'hFFE0, 2'd2);
`ifdef PP_FINAL_SUM_EN
      check("r2sum.dv", 64'(bus.done_valid), 64'(1'b0));
      tick();
      check("r2.product", 64'(bus.product_out), 64'(16'hFFD0));
`endif
      check_status("r2done", 1'b0, 1'b0, 1'b1);
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      check_status("r2idle", 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
